// File: rtl/snake_pkg.sv
// Shared constants for the Snake score path: active-low 7-segment table and BCD limits.
package snake_pkg;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Codes above 9 can only come from a corrupted register; show them blank.
    function automatic logic [7:0] seg_lookup(input logic [3:0] digit);
        if (digit > BCD_MAX) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[digit];
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the score counter; carry is combinational so digits ripple in one cycle.
module bcd_digit
    import snake_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == BCD_MAX);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/score_display_engine.sv
// N-digit BCD score counter with strobed, leading-zero-blanked 7-segment output.
// Define HIGH_SCORE_EN to keep a high score and allow SHOW_HIGH to display it.
module score_display_engine
    import snake_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STROBE_DIV = 100000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    REACHED_TARGET,
    input  logic                    CLEAR_SCORE,
    input  logic                    SHOW_HIGH,
    output logic [4*NUM_DIGITS-1:0] SCORE_BCD,
    output logic                    SCORE_WRAP,
    output logic [4*NUM_DIGITS-1:0] HIGH_SCORE,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT,
    output logic [7:0]              HEX_OUT
);

    localparam int CNT_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic                  prev_target;
    logic                  inc;
    logic [NUM_DIGITS:0]   carry_chain;
    logic                  show_high;
    logic [CNT_W-1:0]      strobe_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [VAL_W-1:0]      disp_val;
    logic [3:0]            cur_digit;
    logic                  upper_zero;
    logic [7:0]            hex_next;
    logic [NUM_DIGITS-1:0] sel_next;

    // prev_target resets high so a level already present at release is not a hit.
    assign inc            = REACHED_TARGET & ~prev_target;
    assign carry_chain[0] = inc;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .CLK   (CLK),
            .RESET (RESET),
            .inc   (carry_chain[gi]),
            .clr   (CLEAR_SCORE),
            .digit (SCORE_BCD[4*gi +: 4]),
            .carry (carry_chain[gi+1])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            prev_target <= 1'b1;
            SCORE_WRAP  <= 1'b0;
        end else begin
            prev_target <= REACHED_TARGET;
            if (CLEAR_SCORE) begin
                SCORE_WRAP <= 1'b0;
            end else if (carry_chain[NUM_DIGITS]) begin
                SCORE_WRAP <= 1'b1;
            end
        end
    end

`ifdef HIGH_SCORE_EN
    assign show_high = SHOW_HIGH;

    // Packed BCD compares correctly as plain unsigned binary; a wrapped score always wins.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIGH_SCORE <= '0;
        end else if (CLEAR_SCORE && (SCORE_WRAP || (SCORE_BCD > HIGH_SCORE))) begin
            HIGH_SCORE <= SCORE_BCD;
        end
    end
`else
    logic unused_show_high;

    assign show_high        = 1'b0;
    assign HIGH_SCORE       = '0;
    assign unused_show_high = SHOW_HIGH;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            strobe_cnt <= '0;
            digit_idx  <= '0;
        end else if (strobe_cnt == CNT_W'(STROBE_DIV - 1)) begin
            strobe_cnt <= '0;
            digit_idx  <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
        end
    end

    always_comb begin
        disp_val   = show_high ? HIGH_SCORE : SCORE_BCD;
        cur_digit  = 4'd0;
        upper_zero = 1'b1;
        sel_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == int'(digit_idx)) begin
                cur_digit   = disp_val[4*i +: 4];
                sel_next[i] = 1'b0;
            end
            if ((i >= int'(digit_idx)) && (disp_val[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        hex_next = ((digit_idx != '0) && upper_zero) ? SEG_BLANK : seg_lookup(cur_digit);
        if ((digit_idx == '0) && !show_high && SCORE_WRAP) begin
            hex_next[DP_BIT] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            SEG_SELECT <= '1;
            HEX_OUT    <= SEG_BLANK;
        end else begin
            SEG_SELECT <= sel_next;
            HEX_OUT    <= hex_next;
        end
    end

endmodule

// File: tb/tb_score_display_engine.sv
// Bench for score_display_engine (NUM_DIGITS=4, STROBE_DIV=4); integer model plus directed literals.
module tb_score_display_engine;

    localparam int ND = 4;
    localparam int SD = 4;
`ifdef HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    localparam logic [7:0] SEG [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REACHED_TARGET = 1'b1;
    logic        CLEAR_SCORE = 1'b0;
    logic        SHOW_HIGH = 1'b0;
    logic [15:0] SCORE_BCD;
    logic        SCORE_WRAP;
    logic [15:0] HIGH_SCORE;
    logic [3:0]  SEG_SELECT;
    logic [7:0]  HEX_OUT;

    score_display_engine #(.NUM_DIGITS(ND), .STROBE_DIV(SD)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .REACHED_TARGET (REACHED_TARGET),
        .CLEAR_SCORE    (CLEAR_SCORE),
        .SHOW_HIGH      (SHOW_HIGH),
        .SCORE_BCD      (SCORE_BCD),
        .SCORE_WRAP     (SCORE_WRAP),
        .HIGH_SCORE     (HIGH_SCORE),
        .SEG_SELECT     (SEG_SELECT),
        .HEX_OUT        (HEX_OUT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int value);
        int v;
        v = value;
        to_bcd = '0;
        for (int i = 0; i < ND; i++) begin
            to_bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
    endfunction

    // Model: score as a plain integer, display position from elapsed cycles.
    int         m_score, m_high, m_ncyc, m_pos, m_disp, m_p10;
    bit         m_wrap, m_prev, m_valid, m_show;
    logic [3:0] m_digit;
    logic [3:0] e_sel;
    logic [7:0] e_hex;

    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge CLK);
            if (!RESET) begin
                m_score = 0; m_high = 0; m_ncyc = 0;
                m_wrap = 1'b0; m_prev = 1'b1; m_valid = 1'b1;
                e_sel = 4'hF; e_hex = 8'hFF;
            end else begin
                m_show  = HS_EN && SHOW_HIGH;
                m_disp  = m_show ? m_high : m_score;
                m_pos   = (m_ncyc / SD) % ND;
                m_p10   = 10 ** m_pos;
                m_digit = 4'((m_disp / m_p10) % 10);
                e_sel   = 4'hF & ~(4'b0001 << m_pos);
                e_hex   = (m_pos > 0 && m_disp < m_p10) ? 8'hFF : SEG[m_digit];
                if (m_pos == 0 && !m_show && m_wrap) e_hex[7] = 1'b0;
                m_ncyc++;
                if (CLEAR_SCORE) begin
                    if (HS_EN && (m_wrap || m_score > m_high)) m_high = m_score;
                    m_score = 0;
                    m_wrap  = 1'b0;
                end else if (REACHED_TARGET && !m_prev) begin
                    m_score++;
                    if (m_score == 10000) begin
                        m_score = 0;
                        m_wrap  = 1'b1;
                    end
                end
                m_prev = REACHED_TARGET;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                check("model_score", 32'(SCORE_BCD), 32'(to_bcd(m_score)));
                check("model_wrap", 32'(SCORE_WRAP), 32'(m_wrap));
                check("model_high", 32'(HIGH_SCORE), 32'(to_bcd(m_high)));
                check("model_sel", 32'(SEG_SELECT), 32'(e_sel));
                check("model_hex", 32'(HEX_OUT), 32'(e_hex));
            end
        end
    end

    task automatic pulse();
        @(negedge CLK); REACHED_TARGET = 1'b1;
        @(negedge CLK); REACHED_TARGET = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) pulse();
    endtask

    task automatic clear_score();
        @(negedge CLK); CLEAR_SCORE = 1'b1;
        @(negedge CLK); CLEAR_SCORE = 1'b0;
    endtask

    task automatic wait_sel(input string name, input logic [3:0] target);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge CLK);
            if (SEG_SELECT == target) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s: SEG_SELECT %b never reached %b", name, SEG_SELECT, target);
        end
    endtask

    logic [3:0] sel_tab [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] hex_tab [0:3] = '{8'hA4, 8'h99, 8'hFF, 8'hFF};

    initial begin
        logic [3:0] last_sel;
        bit aligned;

        RESET = 1'b0;
        REACHED_TARGET = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_sel", 32'(SEG_SELECT), 32'h0000_000F);
        check("rst_hex", 32'(HEX_OUT), 32'h0000_00FF);
        check("rst_score", 32'(SCORE_BCD), 32'h0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("held_at_release", 32'(SCORE_BCD), 32'h0);

        REACHED_TARGET = 1'b0;
        repeat (2) @(negedge CLK);
        REACHED_TARGET = 1'b1;
        @(negedge CLK);
        check("hold_first", 32'(SCORE_BCD), 32'h0001);
        repeat (9) @(negedge CLK);
        check("hold_10", 32'(SCORE_BCD), 32'h0001);
        REACHED_TARGET = 1'b0;
        @(negedge CLK);

        clear_score();
        pulses(9);
        check("carry_9", 32'(SCORE_BCD), 32'h0009);
        pulse();
        check("carry_10", 32'(SCORE_BCD), 32'h0010);

        clear_score();
        pulses(999);
        check("pre_999", 32'(SCORE_BCD), 32'h0999);
        pulse();
        check("carry_1000", 32'(SCORE_BCD), 32'h1000);

        clear_score();
        pulses(9999);
        check("pre_9999", 32'(SCORE_BCD), 32'h9999);
        check("pre_wrap_flag", 32'(SCORE_WRAP), 32'h0);
        pulse();
        check("wrap_score", 32'(SCORE_BCD), 32'h0000);
        check("wrap_flag", 32'(SCORE_WRAP), 32'h1);
        wait_sel("wrap_dp_sel", 4'b1110);
        check("wrap_dp_hex", 32'(HEX_OUT), 32'h0000_0040);
        clear_score();
        check("wrap_cleared", 32'(SCORE_WRAP), 32'h0);

`ifdef HIGH_SCORE_EN
        check("high_after_wrap", 32'(HIGH_SCORE), 32'h0000);
        pulses(12);
        clear_score();
        check("high_12", 32'(HIGH_SCORE), 32'h0012);
        pulses(5);
        clear_score();
        check("high_keep_12", 32'(HIGH_SCORE), 32'h0012);
        SHOW_HIGH = 1'b1;
        wait_sel("show_high_d0", 4'b1110);
        check("show_high_d0_hex", 32'(HEX_OUT), 32'h0000_00A4);
        wait_sel("show_high_d1", 4'b1101);
        check("show_high_d1_hex", 32'(HEX_OUT), 32'h0000_00F9);
        SHOW_HIGH = 1'b0;
`else
        check("high_tied_zero", 32'(HIGH_SCORE), 32'h0000);
        SHOW_HIGH = 1'b1;
`endif

        pulses(42);
        check("scan_score", 32'(SCORE_BCD), 32'h0042);
        last_sel = SEG_SELECT;
        aligned = 1'b0;
        for (int k = 0; k < 40 && !aligned; k++) begin
            @(negedge CLK);
            if (SEG_SELECT == 4'b1110 && last_sel == 4'b0111) aligned = 1'b1;
            last_sel = SEG_SELECT;
        end
        if (!aligned) begin
            tests++;
            fails++;
            $display("FAIL scan_align: SEG_SELECT %b, no 0111->1110 step seen", SEG_SELECT);
        end
        for (int j = 0; j < 16; j++) begin
            check($sformatf("scan_sel_%0d", j), 32'(SEG_SELECT), 32'(sel_tab[j/4]));
            check($sformatf("scan_hex_%0d", j), 32'(HEX_OUT), 32'(hex_tab[j/4]));
            @(negedge CLK);
        end

        CLEAR_SCORE = 1'b1;
        REACHED_TARGET = 1'b1;
        @(negedge CLK);
        check("prio_clear_over_inc", 32'(SCORE_BCD), 32'h0000);
        CLEAR_SCORE = 1'b0;
        REACHED_TARGET = 1'b0;
        SHOW_HIGH = 1'b0;
        repeat (4) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
